mux_tree_reg: RTL

Registered N-way channel selector: the parametrised successor of the registered 2:1 bit-mux. A log2(NCH)-deep tree of registered 2:1 selection layers carries data, valid and channel tag in lockstep, so NCH channels reach one output at one layer per cycle. Adds a valid/tag sideband, a global stall (`enable`), and a round-robin mode that cycles through the channels on its own. Sits between the channel sources and the single downstream consumer.

---
 rtl/mux_tree_pkg.sv | 16 +
 rtl/mux2_layer.sv | 37 +++
 rtl/mux_tree_reg.sv | 103 ++++++++++
 3 files changed

// File: rtl/mux_tree_pkg.sv
// rtl/mux_tree_pkg.sv - shared constants and layer geometry helpers for the registered mux tree
package mux_tree_pkg;

    localparam int MAX_NCH = 16;

    // Number of XLEN-bit entries carried on tree level k (level 0 is the raw input).
    function automatic int layer_entries(input int nch, input int k);
        return nch >> k;
    endfunction

    // Entry offset of tree level k inside one flat bus holding every level back to back.
    function automatic int layer_base(input int nch, input int k);
        return 2 * nch - 2 * (nch >> k);
    endfunction

endpackage

// File: rtl/mux2_layer.sv
// rtl/mux2_layer.sv - one registered layer of NOUT 2:1 XLEN-bit muxes sharing a select bit
module mux2_layer #(
    parameter int XLEN = 5,
    parameter int NOUT = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sel_bit,
    input  logic [2*NOUT*XLEN-1:0] din,
    output logic [NOUT*XLEN-1:0]   dout
);

    logic [NOUT*XLEN-1:0] dout_d;
    logic [NOUT*XLEN-1:0] dout_q;

    always_comb begin
        dout_d = dout_q;
        if (enable) begin
            for (int j = 0; j < NOUT; j++) begin
                dout_d[j*XLEN +: XLEN] = sel_bit ? din[(2*j+1)*XLEN +: XLEN]
                                                 : din[(2*j)*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/mux_tree_reg.sv
// rtl/mux_tree_reg.sv - registered NCH-way channel selector with valid/tag sideband and round-robin mode
module mux_tree_reg #(
    parameter  int XLEN = 5,
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [NCH*XLEN-1:0] data,
    input  logic                in_valid,
    input  logic [SELW-1:0]     sel,
    input  logic                rr_mode,
    output logic [XLEN-1:0]     out,
    output logic                out_valid,
    output logic [SELW-1:0]     out_chan,
    output logic [SELW-1:0]     rr_ptr
);

    import mux_tree_pkg::*;

    localparam int TOTAL = 2 * NCH - 1;

    // Every tree level packed back to back: level 0 is data, the last entry is the output.
    logic [TOTAL*XLEN-1:0] tree;

    logic [SELW-1:0] esel;
    logic [SELW-1:0] rr_ptr_d, rr_ptr_q;
    logic [SELW-1:0] vld_d, vld_q;
    logic [SELW-1:0] chan_d [SELW];
    logic [SELW-1:0] chan_q [SELW];

    assign esel = rr_mode ? rr_ptr_q : sel;
    assign tree[NCH*XLEN-1:0] = data;

    for (genvar k = 0; k < SELW; k++) begin : g_layer
        localparam int IBASE = layer_base(NCH, k);
        localparam int OBASE = layer_base(NCH, k + 1);
        localparam int NOUT  = layer_entries(NCH, k + 1);

        logic sel_bit;

        // Later layers steer with the select bit that travelled alongside their data.
        if (k == 0) begin : g_first
            assign sel_bit = esel[0];
        end else begin : g_later
            assign sel_bit = chan_q[k-1][k];
        end

        mux2_layer #(
            .XLEN (XLEN),
            .NOUT (NOUT)
        ) u_layer (
            .clock   (clock),
            .reset   (reset),
            .enable  (enable),
            .sel_bit (sel_bit),
            .din     (tree[IBASE*XLEN +: 2*NOUT*XLEN]),
            .dout    (tree[OBASE*XLEN +: NOUT*XLEN])
        );
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        vld_d    = vld_q;
        for (int k = 0; k < SELW; k++) begin
            chan_d[k] = chan_q[k];
        end
        if (enable) begin
            if (rr_mode && in_valid) begin
                rr_ptr_d = rr_ptr_q + SELW'(1);
            end
            vld_d[0]  = in_valid;
            chan_d[0] = esel;
            for (int k = 1; k < SELW; k++) begin
                vld_d[k]  = vld_q[k-1];
                chan_d[k] = chan_q[k-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
            vld_q    <= '0;
            for (int k = 0; k < SELW; k++) begin
                chan_q[k] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            vld_q    <= vld_d;
            for (int k = 0; k < SELW; k++) begin
                chan_q[k] <= chan_d[k];
            end
        end
    end

    assign out       = tree[(TOTAL-1)*XLEN +: XLEN];
    assign out_valid = vld_q[SELW-1];
    assign out_chan  = chan_q[SELW-1];
    assign rr_ptr    = rr_ptr_q;

endmodule
